// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: frame-level round-robin scheduler that shares one SPI mode-0
// transmitter between two TX FIFOs, framing each burst with chip select.
module spi_tx_arbiter #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned WORDS_PER_FRAME = 4,
    parameter int unsigned CLK_DIV         = 2,
    parameter int unsigned GAP_CYCLES      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            src_empty,
    input  logic [DATA_WIDTH-1:0] src_data0,
    input  logic [DATA_WIDTH-1:0] src_data1,
    output logic [1:0]            src_rd,
    output logic                  spi_cs_n,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int unsigned CDW = $clog2(CLK_DIV + 1);
    localparam int unsigned BW  = $clog2(DATA_WIDTH + 1);
    localparam int unsigned WW  = $clog2(WORDS_PER_FRAME + 1);
    localparam int unsigned GW  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, READ, LOAD, SHIFT, GAP} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] shreg, shreg_nx;
    logic [CDW-1:0]        div_cnt, div_cnt_nx;
    logic [BW-1:0]         bit_cnt, bit_cnt_nx;
    logic [WW-1:0]         word_cnt, word_cnt_nx, word_inc;
    logic [GW-1:0]         gap_cnt, gap_cnt_nx;
    logic                  rr_ptr, rr_ptr_nx;
    logic [1:0]            src_rd_nx, grant_nx, start_grant;
    logic                  cs_n_nx, sck_nx, mosi_nx, frame_done_nx;
    logic                  g_idx, start_ok, pick_ptr, pick, launch;
    logic [DATA_WIDTH-1:0] src_data_g;

    assign g_idx      = grant[1];
    assign src_data_g = g_idx ? src_data1 : src_data0;
    assign busy       = (state != IDLE);
    assign word_inc   = word_cnt + WW'(1);

    // Channel choice; during GAP the pointer it will hold after exit is used.
    always_comb begin
        start_ok = enable && (src_empty != 2'b11);
        pick_ptr = (state == GAP) ? ~g_idx : rr_ptr;
        if (src_empty == 2'b00) pick = pick_ptr;
        else                    pick = src_empty[0];
        start_grant = pick ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            gap_cnt    <= '0;
            rr_ptr     <= 1'b0;
            src_rd     <= '0;
            grant      <= '0;
            spi_cs_n   <= 1'b1;
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            div_cnt    <= div_cnt_nx;
            bit_cnt    <= bit_cnt_nx;
            word_cnt   <= word_cnt_nx;
            gap_cnt    <= gap_cnt_nx;
            rr_ptr     <= rr_ptr_nx;
            src_rd     <= src_rd_nx;
            grant      <= grant_nx;
            spi_cs_n   <= cs_n_nx;
            spi_sck    <= sck_nx;
            spi_mosi   <= mosi_nx;
            frame_done <= frame_done_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        shreg_nx      = shreg;
        div_cnt_nx    = div_cnt;
        bit_cnt_nx    = bit_cnt;
        word_cnt_nx   = word_cnt;
        gap_cnt_nx    = gap_cnt;
        rr_ptr_nx     = rr_ptr;
        src_rd_nx     = '0;
        grant_nx      = grant;
        cs_n_nx       = spi_cs_n;
        sck_nx        = spi_sck;
        mosi_nx       = spi_mosi;
        frame_done_nx = 1'b0;
        launch        = 1'b0;

        case (state)
            IDLE: launch = start_ok;
            READ: state_nx = LOAD;
            LOAD: begin
                shreg_nx   = src_data_g;
                mosi_nx    = src_data_g[DATA_WIDTH-1];
                bit_cnt_nx = '0;
                div_cnt_nx = '0;
                sck_nx     = 1'b0;
                state_nx   = SHIFT;
            end
            SHIFT: begin
                if (div_cnt == CDW'(CLK_DIV - 1)) begin
                    div_cnt_nx = '0;
                    if (!spi_sck) begin
                        sck_nx = 1'b1;
                    end else begin
                        sck_nx     = 1'b0;
                        shreg_nx   = shreg << 1;
                        mosi_nx    = shreg[DATA_WIDTH-2];
                        bit_cnt_nx = bit_cnt + BW'(1);
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            word_cnt_nx = word_inc;
                            if (word_inc < WW'(WORDS_PER_FRAME) && !src_empty[g_idx]) begin
                                state_nx  = READ;
                                src_rd_nx = grant;
                            end else begin
                                state_nx      = GAP;
                                cs_n_nx       = 1'b1;
                                frame_done_nx = 1'b1;
                                gap_cnt_nx    = '0;
                            end
                        end
                    end
                end else begin
                    div_cnt_nx = div_cnt + CDW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    rr_ptr_nx = ~g_idx;
                    // Starting straight from the last GAP cycle keeps the
                    // CS-high time at exactly GAP_CYCLES for back-to-back frames.
                    if (start_ok) begin
                        launch = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        grant_nx = '0;
                    end
                end else begin
                    gap_cnt_nx = gap_cnt + GW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        if (launch) begin
            state_nx    = READ;
            grant_nx    = start_grant;
            cs_n_nx     = 1'b0;
            src_rd_nx   = start_grant;
            word_cnt_nx = '0;
        end
    end
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: default-timing and fast (CLK_DIV=1, GAP_CYCLES=1)
// instances, each fed by a FIFO model and checked against a word/frame scoreboard.
module tb_spi_tx_arbiter;
    localparam int unsigned DW  = 16;
    localparam int unsigned WPF = 4;
    localparam int unsigned CD  = 2;
    localparam int unsigned GC  = 4;

    typedef struct { logic [1:0] g; int unsigned n; } frame_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset  = 1'b1;
    logic enable = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    always @(negedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- default-timing instance ----------------
    logic [1:0]    src_empty, src_rd, grant;
    logic [DW-1:0] src_data0 = '0, src_data1 = '0;
    logic          spi_cs_n, spi_sck, spi_mosi, busy, frame_done;

    spi_tx_arbiter #(.DATA_WIDTH(DW), .WORDS_PER_FRAME(WPF), .CLK_DIV(CD), .GAP_CYCLES(GC)) dut (
        .clock(clock), .reset(reset), .enable(enable), .src_empty(src_empty),
        .src_data0(src_data0), .src_data1(src_data1), .src_rd(src_rd),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .grant(grant), .busy(busy), .frame_done(frame_done)
    );

    // ---------------- fast instance ----------------
    logic [1:0]    f_empty, f_rd, f_grant;
    logic [DW-1:0] f_data0 = '0, f_data1 = '0;
    logic          f_cs_n, f_sck, f_mosi, f_busy, f_done;

    spi_tx_arbiter #(.DATA_WIDTH(DW), .WORDS_PER_FRAME(WPF), .CLK_DIV(1), .GAP_CYCLES(1)) dut_fast (
        .clock(clock), .reset(reset), .enable(enable), .src_empty(f_empty),
        .src_data0(f_data0), .src_data1(f_data1), .src_rd(f_rd),
        .spi_cs_n(f_cs_n), .spi_sck(f_sck), .spi_mosi(f_mosi),
        .grant(f_grant), .busy(f_busy), .frame_done(f_done)
    );

    // ---------------- FIFO models ----------------
    logic [DW-1:0] mem0 [0:63], mem1 [0:63], fmem0 [0:63], fmem1 [0:63];
    int unsigned wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    int unsigned fwr0 = 0, fwr1 = 0, frd0 = 0, frd1 = 0;

    assign src_empty = {wr1 == rd1, wr0 == rd0};
    assign f_empty   = {fwr1 == frd1, fwr0 == frd0};

    always @(posedge clock) begin
        if (src_rd[0]) begin src_data0 <= mem0[rd0]; rd0 <= rd0 + 1; end
        if (src_rd[1]) begin src_data1 <= mem1[rd1]; rd1 <= rd1 + 1; end
        if (f_rd[0])   begin f_data0 <= fmem0[frd0]; frd0 <= frd0 + 1; end
        if (f_rd[1])   begin f_data1 <= fmem1[frd1]; frd1 <= frd1 + 1; end
    end

    // ---------------- scoreboards ----------------
    logic [DW-1:0] exp0[$], exp1[$], fexp0[$], fexp1[$];
    frame_t        exp_fr[$], fexp_fr[$];
    logic          rr_m = 1'b0, rr_f = 1'b0;

    task automatic push(input bit fast, input bit ch, input logic [DW-1:0] d);
        if (!fast && !ch)     begin mem0[wr0] = d;   wr0++;  exp0.push_back(d);  end
        else if (!fast)       begin mem1[wr1] = d;   wr1++;  exp1.push_back(d);  end
        else if (!ch)         begin fmem0[fwr0] = d; fwr0++; fexp0.push_back(d); end
        else                  begin fmem1[fwr1] = d; fwr1++; fexp1.push_back(d); end
    endtask

    // Frame-level round-robin prediction for words already queued before start.
    task automatic plan(input bit fast, input int unsigned n0_in, input int unsigned n1_in);
        int unsigned n0 = n0_in;
        int unsigned n1 = n1_in;
        int unsigned len;
        logic        ch;
        frame_t      f;
        logic        rr = fast ? rr_f : rr_m;
        while (n0 + n1 != 0) begin
            if (n0 != 0 && n1 != 0) ch = rr;
            else                    ch = (n0 == 0);
            len = ch ? n1 : n0;
            if (len > WPF) len = WPF;
            if (ch) n1 -= len; else n0 -= len;
            f.g = ch ? 2'b10 : 2'b01;
            f.n = len;
            if (fast) fexp_fr.push_back(f); else exp_fr.push_back(f);
            rr = ~ch;
        end
        if (fast) rr_f = rr; else rr_m = rr;
    endtask

    // ---------------- monitor: default instance ----------------
    logic [DW-1:0] sh;
    logic          prev_sck = 1'b0, prev_cs = 1'b1, seen_done = 1'b0;
    int unsigned   bit_n, word_n, rd_n, cs_low, sck_hi, hi_run, t_rd, t_rise, avail;
    frame_t        mf;

    always @(negedge clock) begin
        if (reset) begin
            bit_n = 0; word_n = 0; rd_n = 0; cs_low = 0; sck_hi = 0; hi_run = 0;
            seen_done = 1'b0;
        end else begin
            check("grant_vs_busy", grant != 2'b00, busy);
            if (src_rd != 2'b00) begin
                check("pop_nonempty", src_rd & src_empty, 2'b00);
                check("pop_granted", src_rd & ~grant, 2'b00);
                if (rd_n == 0) t_rd = cyc;
                rd_n++;
            end
            if (!spi_cs_n) cs_low++;
            if (spi_sck) sck_hi++;
            if (spi_sck && !prev_sck) begin
                check("sck_under_cs", spi_cs_n, 1'b0);
                if (word_n == 0 && bit_n == 0) check("first_sck_latency", cyc - t_rd, CD + 2);
                if (bit_n != 0) check("sck_period", cyc - t_rise, 2 * CD);
                t_rise = cyc;
                sh = {sh[DW-2:0], spi_mosi};
                bit_n++;
                if (bit_n == DW) begin
                    bit_n = 0;
                    word_n++;
                    avail = grant[1] ? exp1.size() : exp0.size();
                    check("word_pending", avail != 0, 1'b1);
                    if (avail != 0) check("word_data", sh, grant[1] ? exp1.pop_front() : exp0.pop_front());
                end
            end
            if (frame_done) begin
                check("frame_pending", exp_fr.size() != 0, 1'b1);
                if (exp_fr.size() != 0) begin
                    mf = exp_fr.pop_front();
                    check("frame_grant", grant, mf.g);
                    check("frame_words", word_n, mf.n);
                    check("frame_pops", rd_n, mf.n);
                    check("frame_cs_low", cs_low, mf.n * (2 + 2 * CD * DW));
                    check("frame_sck_high", sck_hi, mf.n * CD * DW);
                end
                check("cs_high_at_done", spi_cs_n, 1'b1);
                word_n = 0; rd_n = 0; cs_low = 0; sck_hi = 0; hi_run = 0;
                seen_done = 1'b1;
            end
            if (!spi_cs_n && prev_cs && seen_done) check("cs_gap_min", hi_run >= GC, 1'b1);
            if (spi_cs_n) hi_run++; else hi_run = 0;
        end
        prev_sck = spi_sck;
        prev_cs  = spi_cs_n;
    end

    // ---------------- monitor: fast instance ----------------
    logic [DW-1:0] fsh;
    logic          fprev_sck = 1'b0, fprev_cs = 1'b1, fseen_done = 1'b0;
    int unsigned   fbit_n, fword_n, fcs_low, fhi_run, ft_rise, favail;
    frame_t        ff;

    always @(negedge clock) begin
        if (reset) begin
            fbit_n = 0; fword_n = 0; fcs_low = 0; fhi_run = 0; fseen_done = 1'b0;
        end else begin
            if (f_rd != 2'b00) check("fast_pop_nonempty", f_rd & f_empty, 2'b00);
            if (!f_cs_n) fcs_low++;
            if (f_sck && !fprev_sck) begin
                if (fbit_n != 0) check("fast_sck_period", cyc - ft_rise, 2);
                ft_rise = cyc;
                fsh = {fsh[DW-2:0], f_mosi};
                fbit_n++;
                if (fbit_n == DW) begin
                    fbit_n = 0;
                    fword_n++;
                    favail = f_grant[1] ? fexp1.size() : fexp0.size();
                    check("fast_word_pending", favail != 0, 1'b1);
                    if (favail != 0) check("fast_word_data", fsh, f_grant[1] ? fexp1.pop_front() : fexp0.pop_front());
                end
            end
            if (f_done) begin
                check("fast_frame_pending", fexp_fr.size() != 0, 1'b1);
                if (fexp_fr.size() != 0) begin
                    ff = fexp_fr.pop_front();
                    check("fast_frame_grant", f_grant, ff.g);
                    check("fast_frame_words", fword_n, ff.n);
                    check("fast_frame_cs_low", fcs_low, ff.n * (2 + 2 * DW));
                end
                fword_n = 0; fcs_low = 0; fhi_run = 0;
                fseen_done = 1'b1;
            end
            if (!f_cs_n && fprev_cs && fseen_done) check("fast_cs_gap", fhi_run, 1);
            if (f_cs_n) fhi_run++; else fhi_run = 0;
        end
        fprev_sck = f_sck;
        fprev_cs  = f_cs_n;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int unsigned n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic wait_drain(input string tag, input bit fast, input int unsigned budget);
        int unsigned k = 0;
        while (k < budget && (fast ? (f_busy || fexp_fr.size() != 0) : (busy || exp_fr.size() != 0))) begin
            tick(1);
            k++;
        end
        if (fast) begin
            check({tag, "_frames_left"}, fexp_fr.size(), 0);
            check({tag, "_idle"}, f_busy, 1'b0);
            check({tag, "_words_left"}, fexp0.size() + fexp1.size(), 0);
        end else begin
            check({tag, "_frames_left"}, exp_fr.size(), 0);
            check({tag, "_idle"}, busy, 1'b0);
            check({tag, "_words_left"}, exp0.size() + exp1.size(), 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"}, spi_cs_n, 1'b1);
        check({tag, "_sck"}, spi_sck, 1'b0);
        check({tag, "_mosi"}, spi_mosi, 1'b0);
        check({tag, "_src_rd"}, src_rd, 2'b00);
        check({tag, "_grant"}, grant, 2'b00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
    endtask

    initial begin
        int unsigned k;
        logic [DW-1:0] t2_words [4];
        t2_words = '{16'hA5C3, 16'h0001, 16'hFFFF, 16'h8000};

        reset = 1'b1; enable = 1'b0;
        tick(3);
        check_reset_outputs("por");

        // Reset in the middle of the first word of a channel-0 frame.
        reset = 1'b0; enable = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            push(0, 0, 16'h1100 + 16'(i));
            push(0, 1, 16'h2200 + 16'(i));
        end
        k = 0;
        while (!spi_sck && k < 100) begin tick(1); k++; end
        check("t1_sck_started", spi_sck, 1'b1);
        tick(20);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("midreset");
        reset = 1'b0;
        void'(exp0.pop_front());
        rr_m = 1'b0;
        plan(0, 3, 4);
        k = 0;
        while (grant == 2'b00 && k < 10) begin tick(1); k++; end
        check("t1_first_grant", grant, 2'b01);
        wait_drain("t1", 0, 3000);

        // Single channel, full frame of known patterns.
        for (int unsigned i = 0; i < 4; i++) push(0, 0, t2_words[i]);
        plan(0, 4, 0);
        wait_drain("t2", 0, 2000);
        check("t2_pops", rd0, wr0);

        // Both channels deep: alternating frames, last two short.
        for (int unsigned i = 0; i < 6; i++) begin
            push(0, 0, 16'h3000 + 16'(i * 7));
            push(0, 1, 16'hC000 + 16'(i * 13));
        end
        plan(0, 6, 6);
        wait_drain("t3", 0, 4000);

        // Short frame: channel 1 with two words only.
        push(0, 1, 16'h5A5A);
        push(0, 1, 16'h0F0F);
        plan(0, 0, 2);
        wait_drain("t4", 0, 1000);
        check("t4_pops", rd1, wr1);

        // Enable dropped during word 2; frame completes, next start blocked.
        for (int unsigned i = 0; i < 4; i++) begin
            push(0, 0, 16'h6000 + 16'(i));
            push(0, 1, 16'h9000 + 16'(i));
        end
        plan(0, 4, 4);
        k = 0;
        while (exp0.size() + exp1.size() > 7 && k < 500) begin tick(1); k++; end
        check("t5_first_word_out", exp0.size() + exp1.size(), 7);
        tick(10);
        enable = 1'b0;
        k = 0;
        while (exp_fr.size() > 1 && k < 1000) begin tick(1); k++; end
        check("t5_first_frame_done", exp_fr.size(), 1);
        tick(GC + 5);
        check("t5_hold_cs_n", spi_cs_n, 1'b1);
        check("t5_hold_busy", busy, 1'b0);
        check("t5_hold_grant", grant, 2'b00);
        tick(20);
        check("t5_still_parked", exp_fr.size(), 1);
        check("t5_still_cs_n", spi_cs_n, 1'b1);
        enable = 1'b1;
        k = 0;
        while (grant == 2'b00 && k < 10) begin tick(1); k++; end
        check("t5_resume_grant", grant, exp_fr[0].g);
        wait_drain("t5", 0, 1000);

        // Fast instance: back-to-back frames with a one-cycle CS gap.
        for (int unsigned i = 0; i < 4; i++) begin
            push(1, 0, 16'h7100 + 16'(i * 3));
            push(1, 1, 16'hE200 + 16'(i * 5));
        end
        plan(1, 4, 4);
        wait_drain("t6", 1, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
